// File: rtl/hash_result_writer.sv
// Buffers incoming hash words in a small FIFO and writes them to consecutive memory addresses starting at a captured base.
// Optional macro HASH_WRITER_CHECKSUM_EN appends one XOR checksum word at base+NUM_NONCES.
module hash_result_writer #(
    parameter int NUM_NONCES = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] output_addr,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        done,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data
);

    localparam int CW = $clog2(NUM_NONCES + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

`ifdef HASH_WRITER_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, RUN, CSUM} state_t;
    logic [31:0] csum;
`else
    typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

    state_t         state;
    logic [15:0]    base;
    logic [CW-1:0]  acc_cnt;
    logic [CW-1:0]  wr_cnt;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [PW:0]    fifo_cnt;
    logic [31:0]    fifo_mem [FIFO_DEPTH];

    logic fifo_full;
    logic push;
    logic pop;
    logic last_pop;

    assign mem_clk   = clk;
    assign fifo_full = (fifo_cnt == (PW+1)'(FIFO_DEPTH));
    // NOTE: in_ready decodes registered state only, so a pop in the same cycle cannot open a full FIFO.
    assign in_ready  = (state == RUN) && !fifo_full && (acc_cnt < CW'(NUM_NONCES));
    assign push      = in_valid && in_ready;
    assign pop       = (state == RUN) && (fifo_cnt != '0);
    assign last_pop  = pop && (wr_cnt == CW'(NUM_NONCES - 1));

    // NOTE: storage carries no reset; validity is defined solely by the pointers and fifo_cnt.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            done           <= 1'b1;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            base           <= '0;
            acc_cnt        <= '0;
            wr_cnt         <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_cnt       <= '0;
`ifdef HASH_WRITER_CHECKSUM_EN
            csum           <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    mem_we <= 1'b0;
                    if (start) begin
                        base     <= output_addr;
                        acc_cnt  <= '0;
                        wr_cnt   <= '0;
                        wr_ptr   <= '0;
                        rd_ptr   <= '0;
                        fifo_cnt <= '0;
`ifdef HASH_WRITER_CHECKSUM_EN
                        csum     <= '0;
`endif
                        done     <= 1'b0;
                        state    <= RUN;
                    end else begin
                        done <= 1'b1;
                    end
                end

                RUN: begin
                    done <= 1'b0;
                    if (push) begin
                        wr_ptr  <= wr_ptr + 1'b1;
                        acc_cnt <= acc_cnt + 1'b1;
                    end
                    if (pop) begin
                        rd_ptr         <= rd_ptr + 1'b1;
                        mem_we         <= 1'b1;
                        mem_addr       <= base + 16'(wr_cnt);
                        mem_write_data <= fifo_mem[rd_ptr];
                        wr_cnt         <= wr_cnt + 1'b1;
`ifdef HASH_WRITER_CHECKSUM_EN
                        csum           <= csum ^ fifo_mem[rd_ptr];
`endif
                    end else begin
                        mem_we <= 1'b0;
                    end
                    if (push && !pop)
                        fifo_cnt <= fifo_cnt + 1'b1;
                    else if (pop && !push)
                        fifo_cnt <= fifo_cnt - 1'b1;
                    if (last_pop) begin
`ifdef HASH_WRITER_CHECKSUM_EN
                        state <= CSUM;
`else
                        state <= IDLE;
`endif
                    end
                end

`ifdef HASH_WRITER_CHECKSUM_EN
                CSUM: begin
                    done           <= 1'b0;
                    mem_we         <= 1'b1;
                    mem_addr       <= base + 16'(NUM_NONCES);
                    mem_write_data <= csum;
                    state          <= IDLE;
                end
`endif

                default: begin
                    mem_we <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hash_result_writer.sv
// Self-checking bench for hash_result_writer: table of jobs, transaction-level write model, reset and address-wrap corners.
module tb_hash_result_writer;

    localparam int N = 16;
    localparam int D = 4;
`ifdef HASH_WRITER_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] output_addr;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        done;
    logic        mem_clk;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;

    hash_result_writer #(.NUM_NONCES(N), .FIFO_DEPTH(D)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .output_addr    (output_addr),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .done           (done),
        .mem_clk        (mem_clk),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Expected write: the cycle it must be visible in, plus address and data.
    typedef struct {
        int          due;
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    // Job description and hand-computed expected first/last data-write addresses.
    typedef struct {
        logic [15:0] base;
        int          vmode;       // 0 held high, 1 alternate, 2 random, 3 bursts of three
        int          dmode;       // 0 0x1000_0000+i, 1 random, 2 i+1
        bit          start_noise; // keep start asserted with a bogus address while running
        int          abort_at;    // pulse reset after this many writes (0: never)
        logic [15:0] first_addr;
        logic [15:0] last_addr;
    } vec_t;

    task automatic run_job(input vec_t v);
        logic [31:0] words [N];
        logic [31:0] x;
        logic [15:0] first_seen;
        logic [15:0] last_seen;
        int          acc;
        int          writes;
        int          dw;
        int          total;
        bit          fire;
        bit          exp_rdy;
        wr_t         w;

        x = '0; acc = 0; writes = 0; first_seen = '0; last_seen = '0;
        for (int i = 0; i < N; i++) begin
            case (v.dmode)
                0:       words[i] = 32'h1000_0000 + 32'(i);
                1:       words[i] = $urandom;
                default: words[i] = 32'(i + 1);
            endcase
            x ^= words[i];
        end
        total = (v.abort_at != 0) ? v.abort_at : (CSUM ? N + 1 : N);
        exp_q.delete();

        @(posedge clk); cyc++; #1;
        start = 1'b1; output_addr = v.base; in_valid = 1'b0;
        @(negedge clk);
        check("idle_done", 32'(done), 32'd1);
        check("idle_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); cyc++; #1;
        if (v.start_noise) output_addr = ~v.base;
        else               start = 1'b0;

        for (int k = 0; k < 400 && writes < total; k++) begin
            if (k > 0) begin
                @(posedge clk); cyc++; #1;
            end
            case (v.vmode)
                0:       in_valid = 1'b1;
                1:       in_valid = (k % 2) == 0;
                2:       in_valid = 1'($urandom_range(0, 1));
                default: in_valid = (k % 6) < 3;
            endcase
            in_data = (acc < N) ? words[acc] : $urandom;
            if (v.start_noise && acc >= N) start = 1'b0;
            @(negedge clk);
            if (k == 0) check("done_low_in_run", 32'(done), 32'd0);

            if (mem_we) begin
                if (exp_q.size() == 0) begin
                    flag("unexpected_write");
                end else begin
                    w = exp_q.pop_front();
                    check("wr_cycle", 32'(cyc), 32'(w.due));
                    check("wr_addr", 32'(mem_addr), 32'(w.addr));
                    check("wr_data", mem_write_data, w.data);
                end
                if (writes == 0) first_seen = mem_addr;
                if (writes < N)  last_seen  = mem_addr;
                writes++;
                if (CSUM && writes == N && v.abort_at == 0)
                    exp_q.push_back('{cyc + 1, v.base + 16'(N), x});
            end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                flag("missing_write");
                void'(exp_q.pop_front());
            end

            dw = (writes < N) ? writes : N;
            exp_rdy = (acc < N) && ((acc - dw) < D);
            check("in_ready", 32'(in_ready), 32'(exp_rdy));

            fire = in_valid && in_ready;
            if (fire && acc < N) begin
                exp_q.push_back('{cyc + 2, v.base + 16'(acc), words[acc]});
                acc++;
            end

            if (v.abort_at != 0 && writes == v.abort_at) begin
                #1 reset_n = 1'b0;
                #1;
                check("abort_mem_we", 32'(mem_we), 32'd0);
                check("abort_done", 32'(done), 32'd1);
                check("abort_in_ready", 32'(in_ready), 32'd0);
                check("abort_mem_addr", 32'(mem_addr), 32'd0);
                in_valid = 1'b1;
                start = 1'b0;
                @(negedge clk);
                reset_n = 1'b1;
                for (int j = 0; j < 3; j++) begin
                    @(posedge clk); cyc++;
                    @(negedge clk);
                    check("post_abort_no_write", 32'(mem_we), 32'd0);
                    check("post_abort_in_ready", 32'(in_ready), 32'd0);
                end
                in_valid = 1'b0;
                check("abort_first_addr", 32'(first_seen), 32'(v.first_addr));
                check("abort_last_addr", 32'(last_seen), 32'(v.last_addr));
                exp_q.delete();
                return;
            end
        end

        if (writes < total) begin
            flag("timeout_waiting_for_writes");
        end else begin
            check("done_with_last_write", 32'(done), 32'd0);
            @(posedge clk); cyc++; #1;
            in_valid = 1'b0;
            @(negedge clk);
            check("done_after_last_write", 32'(done), 32'd1);
            check("no_extra_write", 32'(mem_we), 32'd0);
        end
        check("first_addr", 32'(first_seen), 32'(v.first_addr));
        check("last_addr", 32'(last_seen), 32'(v.last_addr));
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        start = 1'b0;
        in_valid = 1'b0;
    endtask

    vec_t vecs [7];
    vec_t rv;

    initial begin
        vecs[0] = '{16'h0100, 0, 0, 1'b0, 0, 16'h0100, 16'h010F};
        vecs[1] = '{16'h2000, 1, 1, 1'b0, 0, 16'h2000, 16'h200F};
        vecs[2] = '{16'h3000, 3, 1, 1'b0, 0, 16'h3000, 16'h300F};
        vecs[3] = '{16'hFFF8, 0, 0, 1'b0, 0, 16'hFFF8, 16'h0007};
        vecs[4] = '{16'h0400, 0, 2, 1'b1, 0, 16'h0400, 16'h040F};
        vecs[5] = '{16'h0200, 0, 0, 1'b0, 5, 16'h0200, 16'h0204};
        vecs[6] = '{16'h0300, 2, 2, 1'b0, 0, 16'h0300, 16'h030F};

        reset_n = 1'b0; start = 1'b0; output_addr = '0; in_valid = 1'b0; in_data = '0;
        #12;
        check("rst_done", 32'(done), 32'd1);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_data", mem_write_data, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 7; i++)
            run_job(vecs[i]);

        for (int r = 0; r < 3; r++) begin
            rv.base        = 16'($urandom);
            rv.vmode       = 2;
            rv.dmode       = 1;
            rv.start_noise = 1'b0;
            rv.abort_at    = 0;
            rv.first_addr  = rv.base;
            rv.last_addr   = rv.base + 16'(N - 1);
            run_job(rv);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
